// File: rtl/mux_arb.sv
// rtl/mux_arb.sv - two-requester round-robin arbiter with a registered, backpressured output stage
// Optional tie-burst mode is enabled with `define MUX_ARB_BURST_EN.
module mux_arb #(
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_valid,
    input  logic [DATA_WIDTH-1:0] DataA,
    output logic                  a_ready,
    input  logic                  b_valid,
    input  logic [DATA_WIDTH-1:0] DataB,
    output logic                  b_ready,
    output logic                  selectBranch,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD_A = 2'd1,
        HOLD_B = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [DATA_WIDTH-1:0] r_result;
    logic                  r_sel;
    logic                  r_last;
    logic                  w_load;
    logic                  w_any_valid;
    logic                  w_win;
    logic                  w_tie_win;
    logic                  w_accept;

`ifdef MUX_ARB_BURST_EN
    logic [3:0] r_burst_cnt;

    // A zero count means nothing has been accepted since reset, so the tie goes away from r_last.
    assign w_tie_win = ((r_burst_cnt != 4'd0) && (r_burst_cnt < 4'(BURST_LEN))) ? r_last : ~r_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_burst_cnt <= 4'd0;
        end else if (w_accept) begin
            if ((w_win != r_last) || (r_burst_cnt == 4'd0)) begin
                r_burst_cnt <= 4'd1;
            end else if (r_burst_cnt != 4'hF) begin
                r_burst_cnt <= r_burst_cnt + 4'd1;
            end
        end
    end
`else
    logic w_unused_burst_len;

    assign w_unused_burst_len = (BURST_LEN != 0);
    assign w_tie_win          = ~r_last;
`endif

    assign out_valid    = (r_state != IDLE);
    assign selectBranch = r_sel;
    assign result       = r_result;

    assign w_load      = !out_valid || out_ready;
    assign w_any_valid = a_valid || b_valid;
    assign w_accept    = !rst && w_load && w_any_valid;
    assign a_ready     = w_accept && !w_win;
    assign b_ready     = w_accept && w_win;

    // Winner encoding matches selectBranch: 0 = A, 1 = B.
    always_comb begin
        w_win = 1'b0;
        if (a_valid && b_valid) begin
            w_win = w_tie_win;
        end else begin
            w_win = b_valid;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = w_win ? HOLD_B : HOLD_A;
                end
            end
            HOLD_A, HOLD_B: begin
                if (w_accept) begin
                    w_state_next = w_win ? HOLD_B : HOLD_A;
                end else if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_result <= '0;
            r_sel    <= 1'b0;
            r_last   <= 1'b1;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_result <= w_win ? DataB : DataA;
                r_sel    <= w_win;
                r_last   <= w_win;
            end
        end
    end

endmodule

// File: tb/tb_mux_arb.sv
// tb/tb_mux_arb.sv - directed self-checking bench for mux_arb
module tb_mux_arb;

    logic        clk;
    logic        rst;
    logic        a_valid;
    logic [31:0] DataA;
    logic        a_ready;
    logic        b_valid;
    logic [31:0] DataB;
    logic        b_ready;
    logic        selectBranch;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;

    int err_cnt = 0;
    int chk_cnt = 0;

    mux_arb #(
        .DATA_WIDTH(32),
        .BURST_LEN (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .a_valid     (a_valid),
        .DataA       (DataA),
        .a_ready     (a_ready),
        .b_valid     (b_valid),
        .DataB       (DataB),
        .b_ready     (b_ready),
        .selectBranch(selectBranch),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

`ifdef MUX_ARB_BURST_EN
    localparam int N_TIE = 6;
    logic [5:0] tie_sel = 6'b001100;
`else
    localparam int N_TIE = 4;
    logic [5:0] tie_sel = 6'b001010;
`endif

    initial begin
        rst       = 1'b1;
        a_valid   = 1'b1;
        b_valid   = 1'b1;
        DataA     = 32'h0000_000A;
        DataB     = 32'h0000_000B;
        out_ready = 1'b1;

        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_a_ready", a_ready, 1'b0);
            check("rst_b_ready", b_ready, 1'b0);
            after_edge();
            check("rst_out_valid", out_valid, 1'b0);
            check("rst_result", result, 32'h0);
            check("rst_sel", selectBranch, 1'b0);
        end

        rst     = 1'b0;
        b_valid = 1'b0;
        DataA   = 32'h0000_0041;
        @(negedge clk);
        check("single_a_ready", a_ready, 1'b1);
        check("single_b_ready", b_ready, 1'b0);
        after_edge();
        a_valid = 1'b0;
        check("single_result", result, 32'h41);
        check("single_sel", selectBranch, 1'b0);
        check("single_valid", out_valid, 1'b1);
        @(negedge clk);
        check("idle_a_ready", a_ready, 1'b0);
        after_edge();
        check("drain_valid", out_valid, 1'b0);
        check("drain_result_hold", result, 32'h41);

        b_valid = 1'b1;
        DataB   = 32'h0000_0042;
        @(negedge clk);
        check("single_b_ready", b_ready, 1'b1);
        check("single_b_a_ready", a_ready, 1'b0);
        after_edge();
        b_valid = 1'b0;
        check("single_b_result", result, 32'h42);
        check("single_b_sel", selectBranch, 1'b1);

        a_valid = 1'b1;
        DataA   = 32'h4865_6C6C;
        @(negedge clk);
        check("swap_a_ready", a_ready, 1'b1);
        after_edge();
        check("swap_result", result, 32'h4865_6C6C);
        check("swap_sel", selectBranch, 1'b0);
        check("swap_valid", out_valid, 1'b1);

        a_valid   = 1'b0;
        b_valid   = 1'b1;
        DataB     = 32'h2222_2222;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_b_ready", b_ready, 1'b0);
            check("bp_a_ready", a_ready, 1'b0);
            after_edge();
            check("bp_result", result, 32'h4865_6C6C);
            check("bp_sel", selectBranch, 1'b0);
            check("bp_valid", out_valid, 1'b1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_b_ready", b_ready, 1'b1);
        after_edge();
        b_valid = 1'b0;
        check("bp_release_result", result, 32'h2222_2222);
        check("bp_release_sel", selectBranch, 1'b1);
        check("bp_release_valid", out_valid, 1'b1);

        out_ready = 1'b0;
        a_valid   = 1'b1;
        b_valid   = 1'b1;
        DataA     = 32'h0000_0001;
        DataB     = 32'h0000_0002;
        rst       = 1'b1;
        after_edge();
        check("midrst_valid", out_valid, 1'b0);
        check("midrst_result", result, 32'h0);
        check("midrst_sel", selectBranch, 1'b0);
        rst       = 1'b0;
        out_ready = 1'b1;

        for (int i = 0; i < N_TIE; i++) begin
            @(negedge clk);
            check("tie_a_ready", a_ready, !tie_sel[i]);
            check("tie_b_ready", b_ready, tie_sel[i]);
            after_edge();
            check("tie_sel", selectBranch, tie_sel[i]);
            check("tie_result", result, tie_sel[i] ? 32'h2 : 32'h1);
            check("tie_valid", out_valid, 1'b1);
        end

        a_valid = 1'b0;
        b_valid = 1'b0;
        after_edge();
        check("final_drain_valid", out_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/mux_arb.md
# mux_arb

Two-requester round-robin arbiter that shares the 32-bit `DataA`/`DataB` → `result` select path between requester A and requester B. It owns the `selectBranch` control, accepts one word per cycle from the winning requester over valid/ready, and presents it on a registered output stage with backpressure. It sits between two producer stages of the datapath and a single downstream consumer.

## Interface
- `DATA_WIDTH`, 32, width of each data path
- `BURST_LEN`, 4, max consecutive grants to one requester when `MUX_ARB_BURST_EN` is defined; legal range 1..15
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `a_valid`  in  1  requester A has a word
- `DataA`  in  DATA_WIDTH  requester A word
- `a_ready`  out  1  A word accepted this cycle when `a_valid && a_ready`
- `b_valid`  in  1  requester B has a word
- `DataB`  in  DATA_WIDTH  requester B word
- `b_ready`  out  1  B word accepted this cycle when `b_valid && b_ready`
- `selectBranch`  out  1  source of the word in `result`: 0 = A, 1 = B (registered)
- `out_valid`  out  1  `result` holds a word
- `out_ready`  in  1  consumer takes `result` when `out_valid && out_ready`
- `result`  out  DATA_WIDTH  registered output word

## Operation
- Output register is a single entry. `load = !out_valid || out_ready`.
- Winner per cycle (combinational): only A valid → A; only B valid → B; both valid → requester other than `last`; neither → none.
- `a_ready = load && winner==A`; `b_ready = load && winner==B`. At most one ready high per cycle. Ready never depends on `out_valid` of the same requester beyond `load`.
- On accept: `result` ← winner's data, `selectBranch` ← winner, `out_valid` ← 1, `last` ← winner.
- On `out_valid && out_ready` with no accept: `out_valid` ← 0; `result`/`selectBranch` hold last value.
- State machine `{IDLE, HOLD_A, HOLD_B}` mirrors `{out_valid, selectBranch}`: IDLE → HOLD_x on accept from x; HOLD_x → HOLD_y on drain+accept from y (same cycle); HOLD_x → IDLE on drain without accept; HOLD_x holds while `!out_ready`.
- `result`, `selectBranch` are not changed while `out_valid && !out_ready`.

## Timing
- Reset values: `out_valid`=0, `result`=0, `selectBranch`=0, `last`=B (so A wins the first tie), state IDLE, burst counter 0. `a_ready`/`b_ready` are 0 during `rst`.
- Latency: accept in cycle N → `out_valid`/`result` valid in cycle N+1.
- Throughput: one word per cycle while `out_ready`=1; both requesters valid continuously → strict A,B,A,B… alternation.
- Backpressure: `out_ready`=0 with `out_valid`=1 → both readies 0; no word lost or duplicated.
- Simultaneous drain and accept in one cycle: new word replaces old, `out_valid` stays 1.
- Requester dropping valid while not granted: legal; no state change.
- `rst` asserted mid-transfer: in-flight word discarded, all registers return to reset values next edge.

## Configuration
- `MUX_ARB_BURST_EN` defined: 4-bit counter `burst_cnt` counts consecutive accepts from `last`. On a tie, winner stays `last` while `burst_cnt < BURST_LEN`; at `BURST_LEN` the other requester wins and the counter restarts at 1. Switching source for any reason sets the counter to 1.
- Not defined: no counter; ties alternate per word as in Operation; `BURST_LEN` ignored.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with both valid → readies 0, `out_valid`=0, `result`=0, `selectBranch`=0.
- Single requester: A valid with `DataA`="A" (0x41), `out_ready`=1 → `a_ready`=1, next cycle `result`=0x41, `selectBranch`=0.
- Tie round-robin (macro off): both valid with `DataA`=1, `DataB`=2 for 4 cycles, `out_ready`=1 → `result` sequence 1,2,1,2; `selectBranch` 0,1,0,1.
- Backpressure: `out_valid`=1 with `result`=0x48656C6C, `out_ready`=0 for 3 cycles → readies 0, `result` and `selectBranch` stable; `out_ready`=1 → next word loaded same cycle, no gap.
- Burst (macro on, `BURST_LEN`=2): both valid for 6 cycles → `selectBranch` 0,0,1,1,0,0.
- Reset mid-operation: assert `rst` while `out_valid`=1, `out_ready`=0 → next cycle `out_valid`=0, first tie after release goes to A.
